// File: rtl/ysyx_22040386_wb_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22040386_wb_regfile_if
//  Purpose  : Bundle of the MEM/WB write-back slot, the two ID-stage read
//             ports and the commit/trace record of the write-back regfile.
//  Modports : master - driven by the pipeline (WB slot + ID read addresses),
//                      observes read data and the commit record.
//             slave  - the register file side.
//  Signals  : i_WB_RF_valid, i_WB_RF_RegWrite, i_WB_RF_wr_addr,
//             i_WB_RF_wr_data, i_WB_RF_pc, i_WB_RF_rs1_addr, i_WB_RF_rs2_addr
//             (into the regfile); o_WB_RF_rs1_data, o_WB_RF_rs2_data,
//             o_WB_RF_commit, o_WB_RF_commit_pc, o_WB_RF_commit_rd,
//             o_WB_RF_commit_wd, o_WB_RF_retired (out of the regfile).
//  Revision : 1.0 - initial release
// ============================================================================
interface ysyx_22040386_wb_regfile_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5
);
    logic            i_WB_RF_valid;
    logic            i_WB_RF_RegWrite;
    logic [AW-1:0]   i_WB_RF_wr_addr;
    logic [XLEN-1:0] i_WB_RF_wr_data;
    logic [XLEN-1:0] i_WB_RF_pc;
    logic [AW-1:0]   i_WB_RF_rs1_addr;
    logic [AW-1:0]   i_WB_RF_rs2_addr;
    logic [XLEN-1:0] o_WB_RF_rs1_data;
    logic [XLEN-1:0] o_WB_RF_rs2_data;
    logic            o_WB_RF_commit;
    logic [XLEN-1:0] o_WB_RF_commit_pc;
    logic [AW-1:0]   o_WB_RF_commit_rd;
    logic [XLEN-1:0] o_WB_RF_commit_wd;
    logic [XLEN-1:0] o_WB_RF_retired;

    modport master (
        output i_WB_RF_valid, i_WB_RF_RegWrite, i_WB_RF_wr_addr, i_WB_RF_wr_data,
               i_WB_RF_pc, i_WB_RF_rs1_addr, i_WB_RF_rs2_addr,
        input  o_WB_RF_rs1_data, o_WB_RF_rs2_data, o_WB_RF_commit,
               o_WB_RF_commit_pc, o_WB_RF_commit_rd, o_WB_RF_commit_wd,
               o_WB_RF_retired
    );

    modport slave (
        input  i_WB_RF_valid, i_WB_RF_RegWrite, i_WB_RF_wr_addr, i_WB_RF_wr_data,
               i_WB_RF_pc, i_WB_RF_rs1_addr, i_WB_RF_rs2_addr,
        output o_WB_RF_rs1_data, o_WB_RF_rs2_data, o_WB_RF_commit,
               o_WB_RF_commit_pc, o_WB_RF_commit_rd, o_WB_RF_commit_wd,
               o_WB_RF_retired
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22040386_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22040386_wb_regfile
//  Purpose  : Write-back end of the MEM/WB stage. Updates the integer
//             register file, serves two combinational ID read ports with
//             same-cycle WB->ID bypass, and produces a registered commit
//             record plus a retired-instruction counter.
//  Ports    : i_WB_RF_clk   - clock, all state changes on posedge
//             i_WB_RF_rst_n - synchronous active-low reset
//             wb            - slave side of ysyx_22040386_wb_regfile_if
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040386_wb_regfile #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  wire logic                   i_WB_RF_clk,
    input  wire logic                   i_WB_RF_rst_n,
    ysyx_22040386_wb_regfile_if.slave   wb
);

    // Architectural state. Entry 0 is never written (the write enable
    // excludes address 0) and never read (address 0 decodes to zero).
    logic [XLEN-1:0] rf_q [NREG];

    logic            commit_q,    commit_d;
    logic [XLEN-1:0] commit_pc_q, commit_pc_d;
    logic [AW-1:0]   commit_rd_q, commit_rd_d;
    logic [XLEN-1:0] commit_wd_q, commit_wd_d;
    logic [XLEN-1:0] retired_q,   retired_d;

    logic            w_wr_en;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    // Bubbles (valid=0) carry stale RegWrite bits and must not write.
    assign w_wr_en = wb.i_WB_RF_valid && wb.i_WB_RF_RegWrite
                     && (wb.i_WB_RF_wr_addr != '0);

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    always_ff @(posedge i_WB_RF_clk) begin
        if (!i_WB_RF_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (w_wr_en) begin
            rf_q[wb.i_WB_RF_wr_addr] <= wb.i_WB_RF_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Read ports: x0 first, then write-first bypass, then storage.
    // w_wr_en already implies wr_addr != 0, so the bypass can never
    // return data for x0 even without the first test.
    // ------------------------------------------------------------------
    always_comb begin
        w_rs1_data = '0;
        if (wb.i_WB_RF_rs1_addr == '0) begin
            w_rs1_data = '0;
        end else if (w_wr_en && (wb.i_WB_RF_wr_addr == wb.i_WB_RF_rs1_addr)) begin
            w_rs1_data = wb.i_WB_RF_wr_data;
        end else begin
            w_rs1_data = rf_q[wb.i_WB_RF_rs1_addr];
        end
    end

    always_comb begin
        w_rs2_data = '0;
        if (wb.i_WB_RF_rs2_addr == '0) begin
            w_rs2_data = '0;
        end else if (w_wr_en && (wb.i_WB_RF_wr_addr == wb.i_WB_RF_rs2_addr)) begin
            w_rs2_data = wb.i_WB_RF_wr_data;
        end else begin
            w_rs2_data = rf_q[wb.i_WB_RF_rs2_addr];
        end
    end

    assign wb.o_WB_RF_rs1_data = w_rs1_data;
    assign wb.o_WB_RF_rs2_data = w_rs2_data;

    // ------------------------------------------------------------------
    // Commit record and retired counter
    // ------------------------------------------------------------------
    always_comb begin
        commit_d    = wb.i_WB_RF_valid;
        commit_pc_d = commit_pc_q;
        commit_rd_d = commit_rd_q;
        commit_wd_d = commit_wd_q;
        retired_d   = retired_q;
        if (wb.i_WB_RF_valid) begin
            commit_pc_d = wb.i_WB_RF_pc;
            // rd is reported whenever RegWrite is set (x0 reports as 0
            // naturally); data is reported only for a real storage update.
            commit_rd_d = wb.i_WB_RF_RegWrite ? wb.i_WB_RF_wr_addr : '0;
            commit_wd_d = w_wr_en ? wb.i_WB_RF_wr_data : '0;
            // Free-running modulo 2^XLEN.
            retired_d   = retired_q + XLEN'(1);
        end
    end

    always_ff @(posedge i_WB_RF_clk) begin
        if (!i_WB_RF_rst_n) begin
            commit_q    <= 1'b0;
            commit_pc_q <= '0;
            commit_rd_q <= '0;
            commit_wd_q <= '0;
            retired_q   <= '0;
        end else begin
            commit_q    <= commit_d;
            commit_pc_q <= commit_pc_d;
            commit_rd_q <= commit_rd_d;
            commit_wd_q <= commit_wd_d;
            retired_q   <= retired_d;
        end
    end

    assign wb.o_WB_RF_commit    = commit_q;
    assign wb.o_WB_RF_commit_pc = commit_pc_q;
    assign wb.o_WB_RF_commit_rd = commit_rd_q;
    assign wb.o_WB_RF_commit_wd = commit_wd_q;
    assign wb.o_WB_RF_retired   = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040386_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_22040386_wb_regfile
//  Purpose  : Directed, table-driven bench for ysyx_22040386_wb_regfile:
//             reset, write/read with bypass, x0, bubbles, back-to-back
//             writes, high registers and reset in mid-run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040386_wb_regfile;

    localparam int XLEN = 64;
    localparam int AW   = 5;

    logic clk;
    logic rst_n;

    ysyx_22040386_wb_regfile_if #(.XLEN(XLEN), .AW(AW)) wb_if ();

    ysyx_22040386_wb_regfile #(.XLEN(XLEN), .NREG(32), .AW(AW)) dut (
        .i_WB_RF_clk   (clk),
        .i_WB_RF_rst_n (rst_n),
        .wb            (wb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] wa,
                         input logic [63:0] wd, input logic [63:0] pc,
                         input logic [4:0] r1, input logic [4:0] r2);
        wb_if.i_WB_RF_valid    = v;
        wb_if.i_WB_RF_RegWrite = rw;
        wb_if.i_WB_RF_wr_addr  = wa;
        wb_if.i_WB_RF_wr_data  = wd;
        wb_if.i_WB_RF_pc       = pc;
        wb_if.i_WB_RF_rs1_addr = r1;
        wb_if.i_WB_RF_rs2_addr = r2;
    endtask

    typedef struct {
        logic        valid;
        logic        rw;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic [63:0] pc;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [63:0] e_r1;
        logic [63:0] e_r2;
        logic        e_c;
        logic [63:0] e_pc;
        logic [4:0]  e_rd;
        logic [63:0] e_wd;
        logic [63:0] e_ret;
    } vec_t;

    localparam int NV = 12;
    vec_t tv [NV];

    initial begin
        //          v     rw    wa     wd        pc       r1     r2     e_r1      e_r2      e_c   e_pc     e_rd   e_wd      e_ret
        tv[0]  = '{1'b1, 1'b1, 5'd3,  64'h1234, 64'h1000, 5'd3,  5'd5,  64'h1234, 64'h0,    1'b1, 64'h1000, 5'd3,  64'h1234, 64'd1};
        tv[1]  = '{1'b1, 1'b0, 5'd3,  64'hDEAD, 64'h1004, 5'd3,  5'd3,  64'h1234, 64'h1234, 1'b1, 64'h1004, 5'd0,  64'h0,    64'd2};
        tv[2]  = '{1'b1, 1'b1, 5'd0,  64'hFFFF, 64'h1008, 5'd0,  5'd0,  64'h0,    64'h0,    1'b1, 64'h1008, 5'd0,  64'h0,    64'd3};
        tv[3]  = '{1'b1, 1'b0, 5'd0,  64'h0,    64'h100C, 5'd0,  5'd3,  64'h0,    64'h1234, 1'b1, 64'h100C, 5'd0,  64'h0,    64'd4};
        tv[4]  = '{1'b0, 1'b1, 5'd7,  64'h55,   64'h2000, 5'd7,  5'd3,  64'h0,    64'h1234, 1'b0, 64'h100C, 5'd0,  64'h0,    64'd4};
        tv[5]  = '{1'b0, 1'b0, 5'd7,  64'h0,    64'h2004, 5'd7,  5'd7,  64'h0,    64'h0,    1'b0, 64'h100C, 5'd0,  64'h0,    64'd4};
        tv[6]  = '{1'b1, 1'b1, 5'd9,  64'h1,    64'h1010, 5'd9,  5'd9,  64'h1,    64'h1,    1'b1, 64'h1010, 5'd9,  64'h1,    64'd5};
        tv[7]  = '{1'b1, 1'b1, 5'd9,  64'h2,    64'h1014, 5'd9,  5'd9,  64'h2,    64'h2,    1'b1, 64'h1014, 5'd9,  64'h2,    64'd6};
        tv[8]  = '{1'b0, 1'b0, 5'd0,  64'h0,    64'h0,    5'd9,  5'd3,  64'h2,    64'h1234, 1'b0, 64'h1014, 5'd9,  64'h2,    64'd6};
        tv[9]  = '{1'b1, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1018, 5'd31, 5'd30,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h1018, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7};
        tv[10] = '{1'b1, 1'b1, 5'd30, 64'h30,   64'h101C, 5'd31, 5'd30,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'h30, 1'b1, 64'h101C, 5'd30, 64'h30, 64'd8};
        tv[11] = '{1'b0, 1'b0, 5'd0,  64'h0,    64'h0,    5'd31, 5'd30,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'h30, 1'b0, 64'h101C, 5'd30, 64'h30, 64'd8};

        // Reset held for two cycles while a write to x5 is presented.
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 5'd5, 64'hAA, 64'h0, 5'd5, 5'd5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 5'd5, 5'd5);
        #1;
        check("reset_rs1_x5", wb_if.o_WB_RF_rs1_data, 64'h0);
        check("reset_rs2_x5", wb_if.o_WB_RF_rs2_data, 64'h0);
        check("reset_commit", 64'(wb_if.o_WB_RF_commit), 64'h0);
        check("reset_commit_pc", wb_if.o_WB_RF_commit_pc, 64'h0);
        check("reset_retired", wb_if.o_WB_RF_retired, 64'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tv[i].valid, tv[i].rw, tv[i].wa, tv[i].wd, tv[i].pc, tv[i].r1, tv[i].r2);
            #1;
            check($sformatf("v%0d_rs1", i), wb_if.o_WB_RF_rs1_data, tv[i].e_r1);
            check($sformatf("v%0d_rs2", i), wb_if.o_WB_RF_rs2_data, tv[i].e_r2);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_commit", i), 64'(wb_if.o_WB_RF_commit), 64'(tv[i].e_c));
            check($sformatf("v%0d_commit_pc", i), wb_if.o_WB_RF_commit_pc, tv[i].e_pc);
            check($sformatf("v%0d_commit_rd", i), 64'(wb_if.o_WB_RF_commit_rd), 64'(tv[i].e_rd));
            check($sformatf("v%0d_commit_wd", i), wb_if.o_WB_RF_commit_wd, tv[i].e_wd);
            check($sformatf("v%0d_retired", i), wb_if.o_WB_RF_retired, tv[i].e_ret);
        end

        // Two more commits to reach ten, dirtying x1 and x2.
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd1, 64'h11, 64'h1020, 5'd0, 5'd0);
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd2, 64'h22, 64'h1024, 5'd1, 5'd0);
        #1;
        check("pre_rst_x1", wb_if.o_WB_RF_rs1_data, 64'h11);
        @(posedge clk);
        #1;
        check("pre_rst_retired", wb_if.o_WB_RF_retired, 64'd10);

        // One-cycle reset in mid-run; the simultaneous write to x1 is lost.
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 5'd1, 64'h77, 64'h5000, 5'd1, 5'd2);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 5'd1, 5'd2);
        #1;
        check("mid_rst_x1", wb_if.o_WB_RF_rs1_data, 64'h0);
        check("mid_rst_x2", wb_if.o_WB_RF_rs2_data, 64'h0);
        check("mid_rst_commit", 64'(wb_if.o_WB_RF_commit), 64'h0);
        check("mid_rst_commit_pc", wb_if.o_WB_RF_commit_pc, 64'h0);
        check("mid_rst_commit_rd", 64'(wb_if.o_WB_RF_commit_rd), 64'h0);
        check("mid_rst_retired", wb_if.o_WB_RF_retired, 64'h0);
        wb_if.i_WB_RF_rs1_addr = 5'd9;
        wb_if.i_WB_RF_rs2_addr = 5'd31;
        #1;
        check("mid_rst_x9", wb_if.o_WB_RF_rs1_data, 64'h0);
        check("mid_rst_x31", wb_if.o_WB_RF_rs2_data, 64'h0);

        // First instruction after reset counts from one.
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd4, 64'h44, 64'h3000, 5'd4, 5'd9);
        #1;
        check("post_rst_bypass_x4", wb_if.o_WB_RF_rs1_data, 64'h44);
        check("post_rst_x9", wb_if.o_WB_RF_rs2_data, 64'h0);
        @(posedge clk);
        #1;
        check("post_rst_retired", wb_if.o_WB_RF_retired, 64'd1);
        check("post_rst_commit", 64'(wb_if.o_WB_RF_commit), 64'h1);
        check("post_rst_commit_pc", wb_if.o_WB_RF_commit_pc, 64'h3000);
        check("post_rst_commit_rd", 64'(wb_if.o_WB_RF_commit_rd), 64'd4);
        check("post_rst_commit_wd", wb_if.o_WB_RF_commit_wd, 64'h44);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 5'd4, 5'd0);
        #1;
        check("post_rst_x4_stored", wb_if.o_WB_RF_rs1_data, 64'h44);
        @(posedge clk);
        #1;
        check("post_rst_commit_drop", 64'(wb_if.o_WB_RF_commit), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
